// File: rtl/fpu_pkg.sv
// Shared FP64 definitions for the FPU multiply path: widths, latency, flag payload and constants.
package fpu_pkg;

   localparam int unsigned FP64_W      = 64;
   localparam int unsigned MUL_LATENCY = 2;

   localparam logic [FP64_W-1:0] FP64_ONE = 64'h3FF0000000000000;
   localparam logic [FP64_W-1:0] FP64_TWO = 64'h4000000000000000;

   typedef struct packed {
      logic exception;
      logic overflow;
      logic underflow;
   } fp_flags_t;

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Combinational round-robin arbiter; search starts one past the previous winner.
module fpu_rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]           req,
   input  logic [$clog2(N)-1:0]   last_grant,
   input  logic                   enable,
   output logic [N-1:0]           grant,
   output logic [$clog2(N)-1:0]   grant_idx
);

   localparam int unsigned IDX_W = $clog2(N);

   logic              w_found;
   logic [IDX_W-1:0]  w_idx;
   int unsigned       w_cand;

   // First requester found walking forward from last_grant+1 wins.
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_cand  = 0;
      for (int unsigned k = 1; k <= N; k++) begin
         w_cand = (32'(last_grant) + k) % N;
         if (!w_found && req[IDX_W'(w_cand)]) begin
            w_found = 1'b1;
            w_idx   = IDX_W'(w_cand);
         end
      end
   end

   assign grant_idx = w_idx;
   assign grant     = (enable && w_found) ? (N'(1) << w_idx) : '0;

endmodule

// File: rtl/fpu_mul_scheduler.sv
// Round-robin scheduler sharing one external 2-stage FP64 multiplier among NUM_REQ requesters.
// Define FPU_MUL_SCHED_PERF_EN to add saturating issue/stall/idle counters.
module fpu_mul_scheduler
   import fpu_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [FP64_W*NUM_REQ-1:0]  req_a,
   input  logic [FP64_W*NUM_REQ-1:0]  req_b,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [ID_W-1:0]            rsp_id,
   output logic [FP64_W-1:0]          rsp_result,
   output logic [2:0]                 rsp_flags,
   output logic                       mul_enable,
   output logic [FP64_W-1:0]          mul_a,
   output logic [FP64_W-1:0]          mul_b,
   input  logic [FP64_W-1:0]          mul_result,
   input  logic                       mul_exception,
   input  logic                       mul_overflow,
   input  logic                       mul_underflow
`ifdef FPU_MUL_SCHED_PERF_EN
  ,output logic [31:0]                perf_issued
  ,output logic [31:0]                perf_stall
  ,output logic [31:0]                perf_idle
`endif
);

   logic              r_v1;
   logic              r_v2;
   logic [ID_W-1:0]   r_id1;
   logic [ID_W-1:0]   r_id2;
   logic [ID_W-1:0]   r_last_grant;

   logic              w_advance;
   logic              w_arb_en;
   logic              w_issue;
   logic [NUM_REQ-1:0] w_grant;
   logic [ID_W-1:0]   w_gnt_idx;
   fp_flags_t         w_flags;

   logic [FP64_W-1:0] w_op_a [NUM_REQ];
   logic [FP64_W-1:0] w_op_b [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_op_a[gi] = req_a[FP64_W*gi +: FP64_W];
      assign w_op_b[gi] = req_b[FP64_W*gi +: FP64_W];
   end

   // The shadow pipeline and the multiplier move only when the output slot can drain.
   assign w_advance  = !r_v2 || rsp_ready;
   assign mul_enable = w_advance;
   assign w_arb_en   = w_advance && !reset;
   assign w_issue    = w_arb_en && (|req_valid);

   fpu_rr_arbiter #(
      .N          (NUM_REQ)
   ) u_arb (
      .req        (req_valid),
      .last_grant (r_last_grant),
      .enable     (w_arb_en),
      .grant      (w_grant),
      .grant_idx  (w_gnt_idx)
   );

   assign req_ready = w_grant;

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      if (w_issue) begin
         mul_a = w_op_a[w_gnt_idx];
         mul_b = w_op_b[w_gnt_idx];
      end
   end

   // v1/id1 track multiplier stage 1, v2/id2 track its output register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_v1         <= 1'b0;
         r_v2         <= 1'b0;
         r_id1        <= '0;
         r_id2        <= '0;
         r_last_grant <= ID_W'(NUM_REQ - 1);
      end else if (w_advance) begin
         r_v1  <= w_issue;
         r_v2  <= r_v1;
         r_id2 <= r_id1;
         if (w_issue) begin
            r_id1        <= w_gnt_idx;
            r_last_grant <= w_gnt_idx;
         end
      end
   end

   always_comb begin
      w_flags.exception = mul_exception;
      w_flags.overflow  = mul_overflow;
      w_flags.underflow = mul_underflow;
   end

   assign rsp_valid  = r_v2;
   assign rsp_id     = r_id2;
   assign rsp_result = mul_result;
   assign rsp_flags  = w_flags;

`ifdef FPU_MUL_SCHED_PERF_EN
   logic [31:0] r_perf_issued;
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_idle;

   // Saturating event counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_perf_issued <= '0;
         r_perf_stall  <= '0;
         r_perf_idle   <= '0;
      end else begin
         if (w_issue && (r_perf_issued != '1))
            r_perf_issued <= r_perf_issued + 32'd1;
         if (!w_advance && (r_perf_stall != '1))
            r_perf_stall <= r_perf_stall + 32'd1;
         if (w_advance && !w_issue && (r_perf_idle != '1))
            r_perf_idle <= r_perf_idle + 32'd1;
      end
   end

   assign perf_issued = r_perf_issued;
   assign perf_stall  = r_perf_stall;
   assign perf_idle   = r_perf_idle;
`endif

endmodule

// File: tb/tb_fpu_mul_scheduler.sv
// Scoreboard bench for fpu_mul_scheduler with a behavioural 2-stage multiplier and round-robin model.
module tb_fpu_mul_scheduler;
   import fpu_pkg::*;

   localparam int unsigned N    = 4;
   localparam int unsigned ID_W = 2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [N-1:0]         req_valid;
   logic [N-1:0]         req_ready;
   logic [64*N-1:0]      req_a;
   logic [64*N-1:0]      req_b;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [ID_W-1:0]      rsp_id;
   logic [63:0]          rsp_result;
   logic [2:0]           rsp_flags;
   logic                 mul_enable;
   logic [63:0]          mul_a;
   logic [63:0]          mul_b;
   logic [63:0]          m_s1_r;
   logic [2:0]           m_s1_f;
   logic [63:0]          m_res;
   logic [2:0]           m_fl;
`ifdef FPU_MUL_SCHED_PERF_EN
   logic [31:0]          perf_issued;
   logic [31:0]          perf_stall;
   logic [31:0]          perf_idle;
`endif

   always #5 clk = ~clk;

   fpu_mul_scheduler #(.NUM_REQ(N), .ID_W(ID_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_a         (req_a),
      .req_b         (req_b),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_id        (rsp_id),
      .rsp_result    (rsp_result),
      .rsp_flags     (rsp_flags),
      .mul_enable    (mul_enable),
      .mul_a         (mul_a),
      .mul_b         (mul_b),
      .mul_result    (m_res),
      .mul_exception (m_fl[2]),
      .mul_overflow  (m_fl[1]),
      .mul_underflow (m_fl[0])
`ifdef FPU_MUL_SCHED_PERF_EN
     ,.perf_issued   (perf_issued)
     ,.perf_stall    (perf_stall)
     ,.perf_idle     (perf_idle)
`endif
   );

   function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
      real ra, rb;
      ra = $bitstoreal(a);
      rb = $bitstoreal(b);
      return $realtobits(ra * rb);
   endfunction

   // {exception, overflow, underflow} of an IEEE double product
   function automatic logic [2:0] fflags(input logic [63:0] a, input logic [63:0] b);
      logic [63:0] p;
      logic a_fin, b_fin, p_nan, p_inf, tiny;
      p     = fmul(a, b);
      a_fin = (a[62:52] != 11'h7FF);
      b_fin = (b[62:52] != 11'h7FF);
      p_nan = (p[62:52] == 11'h7FF) && (p[51:0] != 52'd0);
      p_inf = (p[62:52] == 11'h7FF) && (p[51:0] == 52'd0);
      tiny  = (p[62:52] == 11'd0) && (a[62:0] != 63'd0) && (b[62:0] != 63'd0);
      return {p_nan, p_inf && a_fin && b_fin, tiny && a_fin && b_fin};
   endfunction

   // External multiplier stand-in: stage register then output register, both gated by enable.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_s1_r <= '0; m_s1_f <= '0; m_res <= '0; m_fl <= '0;
      end else if (mul_enable) begin
         m_s1_r <= fmul(mul_a, mul_b);
         m_s1_f <= fflags(mul_a, mul_b);
         m_res  <= m_s1_r;
         m_fl   <= m_s1_f;
      end
   end

   typedef struct {
      logic [ID_W-1:0] id;
      logic [63:0]     res;
      logic [2:0]      fl;
      int              adv;
   } exp_t;

   exp_t        sb[$];
   int unsigned grant_log[$];
   int unsigned m_last;
   int unsigned dut_acc [N];
   logic [N-1:0] acc;
   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: response scoreboard, enable rule and round-robin grant model, sampled mid-cycle.
   always @(negedge clk) begin
      logic         exp_rv, exp_adv, found;
      logic [N-1:0] exp_rdy;
      int unsigned  win, c;
      logic [63:0]  a, b;
      if (!reset) begin
         exp_rv  = (sb.size() > 0) && (sb[0].adv >= 2);
         exp_adv = !exp_rv || rsp_ready;
         chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
         chk("mul_enable", 64'(mul_enable), 64'(exp_adv));
         if (exp_rv && rsp_valid) begin
            chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
            chk("rsp_result", rsp_result, sb[0].res);
            chk("rsp_flags", 64'(rsp_flags), 64'(sb[0].fl));
         end
         found = 1'b0; win = 0; exp_rdy = '0;
         if (exp_adv) begin
            for (int unsigned k = 1; k <= N; k++) begin
               c = (m_last + k) % N;
               if (!found && req_valid[c]) begin found = 1'b1; win = c; end
            end
         end
         if (found) exp_rdy[win] = 1'b1;
         chk("req_ready", 64'(req_ready), 64'(exp_rdy));
         if (exp_rv && rsp_ready) void'(sb.pop_front());
         if (exp_adv)
            for (int j = 0; j < sb.size(); j++) sb[j].adv = sb[j].adv + 1;
         if (found) begin
            m_last = win;
            grant_log.push_back(win);
         end
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               a = req_a[64*i +: 64];
               b = req_b[64*i +: 64];
               sb.push_back('{id: ID_W'(i), res: fmul(a, b), fl: fflags(a, b), adv: 1});
               acc[i] = 1'b1;
               dut_acc[i]++;
            end
         end
      end
   end

   function automatic logic [63:0] rand_fp();
      logic [63:0] m;
      logic [10:0] e;
      int unsigned r;
      m = {$urandom, $urandom};
      r = $urandom % 16;
      if (r == 0)      e = 11'(32'h7E0 + ($urandom % 31));
      else if (r == 1) e = 11'(32'd1 + ($urandom % 16));
      else             e = 11'(32'h3F0 + ($urandom % 32));
      return {m[63], e, m[51:0]};
   endfunction

   task automatic new_op(input int i, input logic [63:0] a, input logic [63:0] b);
      req_a[64*i +: 64] = a;
      req_b[64*i +: 64] = b;
      req_valid[i] = 1'b1;
   endtask

   // Advance one cycle; accepted requesters withdraw their request.
   task automatic tick();
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc;
      acc = '0;
   endtask

   task automatic drain();
      int k;
      rsp_ready = 1'b1;
      for (k = 0; k < 200; k++) begin
         if (sb.size() == 0 && req_valid == '0) break;
         tick();
      end
      chk("drain_done", 64'(k < 200), 64'(1));
   endtask

   task automatic wait_rsp(output int lat);
      lat = -1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (rsp_valid) begin lat = k; break; end
         tick();
      end
   endtask

   initial begin
      int lat, base;
      logic [63:0] held;
      #30_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int lat, base;
      logic [63:0] held;
      reset = 1'b1; rsp_ready = 1'b1; req_valid = '0; req_a = '0; req_b = '0; acc = '0;
      m_last = N - 1;
      for (int i = 0; i < N; i++) dut_acc[i] = 0;
      for (int i = 0; i < N; i++) new_op(i, rand_fp(), rand_fp());
      #3;
      chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("reset_req_ready", 64'(req_ready), 64'(0));
`ifdef FPU_MUL_SCHED_PERF_EN
      chk("reset_perf_issued", 64'(perf_issued), 64'(0));
`endif
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Fairness: everyone requesting for eight grants
      grant_log.delete();
      for (int c = 0; c < 8; c++) begin
         tick();
         if (c < 7) begin
            for (int i = 0; i < N; i++) if (!req_valid[i]) new_op(i, rand_fp(), rand_fp());
         end else req_valid = '0;
      end
      chk("fair_len", 64'(grant_log.size()), 64'(8));
      for (int k = 0; k < 8 && k < grant_log.size(); k++)
         chk($sformatf("fair_grant%0d", k), 64'(grant_log[k]), 64'(k % 4));
      drain();

      // Single op from requester 2
      base = dut_acc[2];
      new_op(2, 64'h4000000000000000, 64'h4008000000000000);
      wait_rsp(lat);
      chk("single_latency", 64'(lat), 64'(2));
      chk("single_id", 64'(rsp_id), 64'(2));
      chk("single_result", rsp_result, 64'h4018000000000000);
      chk("single_flags", 64'(rsp_flags), 64'(0));
      tick(); drain();
      chk("single_accepts", 64'(dut_acc[2] - base), 64'(1));

      // Overflow passthrough
      new_op(0, 64'h7FE0000000000000, 64'h4000000000000000);
      wait_rsp(lat);
      chk("ovf_result", rsp_result, 64'h7FF0000000000000);
      chk("ovf_flags", 64'(rsp_flags), 64'(3'b010));
      tick(); drain();

      // Back-pressure: three ops, then five stalled cycles with a pending request
      new_op(0, rand_fp(), rand_fp()); tick();
      new_op(1, rand_fp(), rand_fp()); tick();
      new_op(3, rand_fp(), rand_fp()); tick();
      rsp_ready = 1'b0;
      new_op(2, rand_fp(), rand_fp());
      held = '0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 0) held = rsp_result;
         else chk("bp_result_stable", rsp_result, held);
         chk("bp_mul_enable", 64'(mul_enable), 64'(0));
         chk("bp_req_ready", 64'(req_ready), 64'(0));
         tick();
      end
      drain();

      // Bubble fill: requester 1 keeps asking while the output is blocked
      base = dut_acc[1];
      rsp_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (!req_valid[1]) new_op(1, rand_fp(), rand_fp());
         tick();
      end
      @(negedge clk);
      chk("bubble_accepts", 64'(dut_acc[1] - base), 64'(2));
      chk("bubble_v2_held", 64'(rsp_valid), 64'(1));
      tick();
      drain();

      // Randomised traffic with random back-pressure
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++)
            if (!req_valid[i] && ($urandom % 2 == 0)) new_op(i, rand_fp(), rand_fp());
         rsp_ready = ($urandom % 10) < 7;
         tick();
      end
      drain();

      // Reset with both pipeline slots full
      rsp_ready = 1'b0;
      new_op(0, rand_fp(), rand_fp());
      new_op(1, rand_fp(), rand_fp());
      tick(); tick();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("midrst_req_ready", 64'(req_ready), 64'(0));
`ifdef FPU_MUL_SCHED_PERF_EN
      chk("midrst_perf_issued", 64'(perf_issued), 64'(0));
      chk("midrst_perf_stall", 64'(perf_stall), 64'(0));
      chk("midrst_perf_idle", 64'(perf_idle), 64'(0));
`endif
      sb.delete();
      m_last = N - 1;
      acc = '0;
      for (int i = 0; i < N; i++) new_op(i, rand_fp(), rand_fp());
      @(posedge clk);
      #1 reset = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("midrst_first_grant", 64'(req_ready), 64'(4'b0001));
      tick();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
